decode_sequencer: RTL and testbench



---
 rtl/decode_pkg.sv | 20 ++
 rtl/instr_fifo.sv | 64 ++++++
 rtl/decode_sequencer.sv | 130 +++++++++++++
 tb/tb_decode_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants and FSM state type for the decode sequencer
package decode_pkg;

  localparam int BYTE    = 8;
  localparam int INSTR_W = 4 * BYTE;
  localparam int OPC_MSB = INSTR_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } seq_state_t;

  // Opcode field of a raw instruction (top byte).
  function automatic logic [BYTE-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB -: BYTE];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - synchronous instruction FIFO with occupancy count
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push alongside a pop.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// rtl/decode_sequencer.sv - buffers instructions and sequences the decoder with a timeout guard
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int WIDTH_IN   = INSTR_W,
  parameter int WIDTH_OUT  = INSTR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH_IN-1:0]         in_instr,
  output logic                        dec_start,
  output logic [WIDTH_IN-1:0]         dec_instr,
  input  logic [WIDTH_OUT-1:0]        dec_result,
  input  logic                        dec_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH_OUT-1:0]        out_instr,
  output logic                        out_error,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  seq_state_t           r_state;
  logic                 r_dec_start;
  logic [WIDTH_IN-1:0]  r_dec_instr;
  logic                 r_out_valid;
  logic [WIDTH_OUT-1:0] r_out_instr;
  logic                 r_out_error;
  logic [CNT_W-1:0]     r_cnt;

  logic [WIDTH_IN-1:0]          w_fifo_head;
  logic [$clog2(FIFO_DEPTH):0]  w_fifo_count;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic                         w_push;
  logic                         w_pop;

  assign in_ready   = !w_fifo_full;
  assign w_push     = in_valid && in_ready;
  // Pop happens exactly when the FSM moves into ISSUE: from IDLE, or from OUT on acceptance.
  assign w_pop      = !w_fifo_empty &&
                      ((r_state == IDLE) || ((r_state == OUT) && out_ready));

  assign dec_start  = r_dec_start;
  assign dec_instr  = r_dec_instr;
  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_instr;
  assign out_error  = r_out_error;
  assign busy       = (r_state != IDLE) || !w_fifo_empty;
  assign fifo_count = w_fifo_count;

  instr_fifo #(
    .WIDTH (WIDTH_IN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_instr),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Sequencer FSM: issue, wait for the decoder (or time out), then hold the result until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dec_start <= 1'b0;
      r_dec_instr <= '0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_error <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_dec_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            r_dec_instr <= w_fifo_head;
            r_dec_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A ready on the final wait cycle still counts as a good decode.
          if (dec_ready) begin
            r_out_instr <= dec_result;
            r_out_error <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end else if (r_cnt == CNT_LAST) begin
            r_out_instr <= WIDTH_OUT'(r_dec_instr);
            r_out_error <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (!w_fifo_empty) begin
              r_dec_instr <= w_fifo_head;
              r_dec_start <= 1'b1;
              r_state     <= ISSUE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_sequencer.sv
// tb/tb_decode_sequencer.sv - self-checking bench for decode_sequencer
module tb_decode_sequencer;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_instr;
  logic          dec_start;
  logic [W-1:0]  dec_instr;
  logic [W-1:0]  dec_result = '0;
  logic          dec_ready = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_instr;
  logic          out_error;
  logic          busy;
  logic [CW-1:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  decode_sequencer #(
    .WIDTH_IN   (W),
    .WIDTH_OUT  (W),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .dec_start  (dec_start),
    .dec_instr  (dec_instr),
    .dec_result (dec_result),
    .dec_ready  (dec_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_error  (out_error),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- decoder environment ----------------
  bit          rand_mode   = 1'b0;
  int          rdy_pct     = 50;
  int          resp_delay  = 0;
  bit          use_fixed   = 1'b0;
  logic [W-1:0] fixed_res  = '0;
  bit          force_ready = 1'b0;
  int          widx        = -1;
  logic        saw_start   = 1'b0;

  always @(negedge clk) saw_start = dec_start;

  always @(posedge clk) begin
    if (!rst_n) widx = -1;
    else if (saw_start === 1'b1) widx = 0;
    else if (widx >= 0) widx = widx + 1;
    #1;
    if (rand_mode) begin
      dec_ready  = ($urandom_range(0, 99) < rdy_pct);
      dec_result = $urandom;
    end else begin
      dec_ready  = force_ready || (widx >= 0 && widx == resp_delay);
      dec_result = use_fixed ? fixed_res : ~dec_instr;
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [W-1:0] m_q[$];
  bit           m_live = 1'b0;
  bit           m_have = 1'b0;
  bit           m_done = 1'b0;
  int           m_age  = 0;
  logic [W-1:0] m_cur  = '0;
  logic [W-1:0] m_res  = '0;
  bit           m_err  = 1'b0;
  bit           m_push;
  bit           m_issue;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_have = 0; m_done = 0; m_age = 0; m_cur = '0; m_live = 1;
    end else if (m_live) begin
      m_push  = in_valid && (m_q.size() != DEPTH);
      m_issue = 0;
      if (!m_have) begin
        m_issue = (m_q.size() > 0);
      end else if (m_done) begin
        if (out_ready) begin
          m_have  = 0;
          m_issue = (m_q.size() > 0);
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else begin
        if (dec_ready) begin
          m_done = 1; m_res = dec_result; m_err = 0;
        end else if (m_age == TMO) begin
          m_done = 1; m_res = m_cur; m_err = 1;
        end
        m_age++;
      end
      if (m_issue) begin
        m_cur  = m_q.pop_front();
        m_have = 1; m_done = 0; m_age = 0;
      end
      if (m_push) m_q.push_back(in_instr);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_fifo_count", 32'(fifo_count), m_q.size());
      check("model_in_ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
      check("model_busy", 32'(busy), 32'(m_have || m_q.size() != 0));
      check("model_dec_start", 32'(dec_start), 32'(m_have && m_age == 0));
      check("model_dec_instr", dec_instr, m_cur);
      check("model_out_valid", 32'(out_valid), 32'(m_have && m_done));
      if (m_have && m_done) begin
        check("model_out_instr", out_instr, m_res);
        check("model_out_error", 32'(out_error), 32'(m_err));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios, then random traffic ----------------
  logic [W-1:0] exp_q[$];
  int starts, outs, start_k, out_k, acc, got, last_k, last_start, wcyc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dec_start", 32'(dec_start), 0);
    check("rst_fifo_count", 32'(fifo_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dec_instr", dec_instr, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_error", 32'(out_error), 0);
    in_valid = 1'b0; rst_n = 1'b1;
    step();

    // Single decode, result one cycle after start.
    use_fixed = 1; fixed_res = 32'h1234_5678; resp_delay = 0; out_ready = 1;
    in_valid = 1; in_instr = 32'h01AB_CDEF; step(); in_valid = 0;
    starts = 0; outs = 0; start_k = -1; out_k = -1;
    for (int k = 0; k < 10; k++) begin
      if (dec_start) begin
        starts++; start_k = k;
        check("single_dec_instr", dec_instr, 32'h01AB_CDEF);
      end
      if (out_valid) begin
        outs++; out_k = k;
        check("single_out_instr", out_instr, 32'h1234_5678);
        check("single_out_error", 32'(out_error), 0);
      end
      step();
    end
    check("single_start_count", starts, 1);
    check("single_out_count", outs, 1);
    check("single_start_latency", start_k, 1);
    check("single_out_latency", out_k, 3);

    // Backpressure: six pushes against a stalled output.
    use_fixed = 0; out_ready = 0; acc = 0; exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_instr = 32'hA000_0000 + i;
      if (in_ready) begin acc++; exp_q.push_back(in_instr); end
      step();
    end
    in_valid = 0;
    check("bp_accepted", acc, 5);
    check("bp_fifo_count", 32'(fifo_count), 4);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    out_ready = 1; got = 0; last_k = 0;
    for (int k = 0; k < 40 && got < 5; k++) begin
      check("bp_busy", 32'(busy), 1);
      if (out_valid) begin
        if (got < exp_q.size()) check("bp_order", out_instr, ~exp_q[got]);
        if (got > 0) check("bp_back_to_back_gap", k - last_k, 3);
        last_k = k; got++;
      end
      step();
    end
    check("bp_outputs", got, 5);
    step(); step();
    check("bp_idle_busy", 32'(busy), 0);

    // Timeout on the first instruction, normal decode on the next.
    resp_delay = -1;
    in_valid = 1; in_instr = 32'hC0DE_0001; step();
    in_instr = 32'hC0DE_0002; step(); in_valid = 0;
    got = 0; last_start = 0;
    for (int k = 0; k < 80 && got < 2; k++) begin
      if (dec_start) last_start = k;
      if (out_valid) begin
        wcyc = k - last_start - 1;
        if (got == 0) begin
          check("tmo_error", 32'(out_error), 1);
          check("tmo_raw_instr", out_instr, 32'hC0DE_0001);
          check("tmo_wait_cycles", wcyc, TMO);
          resp_delay = 0;
        end else begin
          check("tmo_next_error", 32'(out_error), 0);
          check("tmo_next_instr", out_instr, ~32'hC0DE_0002);
          check("tmo_next_wait_cycles", wcyc, 1);
        end
        got++;
      end
      step();
    end
    check("tmo_outputs", got, 2);
    step(); step();

    // Ready arriving on the last wait cycle wins over the timeout.
    resp_delay = TMO - 1;
    in_valid = 1; in_instr = 32'h5EED_00FF; step(); in_valid = 0;
    got = 0; last_start = 0;
    for (int k = 0; k < 40 && got < 1; k++) begin
      if (dec_start) last_start = k;
      if (out_valid) begin
        check("edge_error", 32'(out_error), 0);
        check("edge_instr", out_instr, ~32'h5EED_00FF);
        check("edge_wait_cycles", k - last_start - 1, TMO);
        got++;
      end
      step();
    end
    check("edge_outputs", got, 1);
    step(); step();

    // Reset while waiting with three entries queued; a late ready must be ignored.
    resp_delay = -1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_instr = 32'hB000_0000 + i; step();
    end
    in_valid = 0;
    step(); step();
    check("mid_fifo_count", 32'(fifo_count), 3);
    check("mid_busy", 32'(busy), 1);
    rst_n = 0; step(); rst_n = 1;
    check("mid_rst_fifo_count", 32'(fifo_count), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    force_ready = 1; step(); force_ready = 0;
    outs = 0; starts = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) outs++;
      if (dec_start) starts++;
      step();
    end
    check("late_ready_out_valid", outs, 0);
    check("late_ready_dec_start", starts, 0);

    // Random traffic against the model.
    rand_mode = 1;
    for (int seg = 0; seg < 4; seg++) begin
      case (seg)
        0:       rdy_pct = 50;
        1:       rdy_pct = 4;
        2:       rdy_pct = 100;
        default: rdy_pct = 20;
      endcase
      for (int c = 0; c < 800; c++) begin
        in_valid  = ($urandom_range(0, 1) == 1);
        in_instr  = $urandom;
        out_ready = ($urandom_range(0, 3) != 0);
        rst_n     = ($urandom_range(0, 299) != 0);
        step();
      end
    end
    rst_n = 1; in_valid = 0; out_ready = 1; rdy_pct = 50;
    repeat (60) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
